ysyx_23060332_ifu: RTL and testbench

Instruction fetch unit; sits directly upstream of the decode stage. Holds the PC and issues one fetch at a time over a simple req/gnt/rvalid instruction-memory port. Presents each fetched word, with its address, to decode over a valid/ready handshake. Accepts jump redirects from the execute stage.

---
 rtl/ysyx_23060332_ifu.sv | 129 ++++++++++++
 tb/tb_ysyx_23060332_ifu.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060332_ifu.sv
// Instruction fetch unit: holds the PC, issues one req/gnt/rvalid fetch at a time and
// presents each word to decode over valid/ready. Optional: YSYX_23060332_IFU_MISALIGN_CHK_EN.
module ysyx_23060332_ifu #(
  parameter int unsigned              ADDR_W   = 32,
  parameter int unsigned              INST_W   = 32,
  parameter logic        [ADDR_W-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [INST_W-1:0] mem_rdata_i,
  output logic              inst_valid_o,
  input  logic              inst_ready_i,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_addr_o,
  input  logic              jump_flag_i,
`ifdef YSYX_23060332_IFU_MISALIGN_CHK_EN
  input  logic [ADDR_W-1:0] jump_addr_i,
  output logic              misalign_o
`else
  input  logic [ADDR_W-1:0] jump_addr_i
`endif
);

  typedef enum logic [2:0] {StIdle, StReq, StWait, StValid, StHalt} state_e;

  state_e              r_state, w_state_d;
  logic [ADDR_W-1:0]   r_pc, w_pc_d;
  logic                r_drop, w_drop_d;
  logic [INST_W-1:0]   r_inst, w_inst_d;
  logic [ADDR_W-1:0]   r_inst_addr, w_inst_addr_d;
  logic [ADDR_W-1:0]   w_jump_tgt;

`ifdef YSYX_23060332_IFU_MISALIGN_CHK_EN
  logic w_jump_bad;
  assign w_jump_tgt = jump_addr_i;
  assign w_jump_bad = jump_flag_i && (jump_addr_i[1:0] != 2'b00);
`else
  // Without the checker a misaligned target is silently word-aligned.
  assign w_jump_tgt = {jump_addr_i[ADDR_W-1:2], 2'b00};
`endif

  always_comb begin
    w_state_d     = r_state;
    w_pc_d        = r_pc;
    w_drop_d      = r_drop;
    w_inst_d      = r_inst;
    w_inst_addr_d = r_inst_addr;
    unique case (r_state)
      StIdle: begin
        w_state_d = StReq;
        if (jump_flag_i) w_pc_d = w_jump_tgt;
      end
      StReq: begin
        if (mem_gnt_i) w_state_d = StWait;
        if (jump_flag_i) begin
          w_pc_d = w_jump_tgt;
          // Granted fetch is for the old PC; its response must be thrown away.
          if (mem_gnt_i) w_drop_d = 1'b1;
        end
      end
      StWait: begin
        if (jump_flag_i) w_pc_d = w_jump_tgt;
        if (mem_rvalid_i) begin
          if (r_drop || jump_flag_i) begin
            w_drop_d  = 1'b0;
            w_state_d = StReq;
          end else begin
            w_inst_d      = mem_rdata_i;
            w_inst_addr_d = r_pc;
            w_state_d     = StValid;
          end
        end else if (jump_flag_i) begin
          w_drop_d = 1'b1;
        end
      end
      StValid: begin
        if (jump_flag_i) begin
          w_pc_d    = w_jump_tgt;
          w_state_d = StReq;
        end else if (inst_ready_i) begin
          w_pc_d    = r_pc + ADDR_W'(4);
          w_state_d = StReq;
        end
      end
      StHalt: begin
        w_state_d = StHalt;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
`ifdef YSYX_23060332_IFU_MISALIGN_CHK_EN
    if (w_jump_bad && (r_state != StHalt)) begin
      w_state_d = StHalt;
      w_drop_d  = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_pc        <= RESET_PC;
      r_drop      <= 1'b0;
      r_inst      <= '0;
      r_inst_addr <= '0;
    end else begin
      r_state     <= w_state_d;
      r_pc        <= w_pc_d;
      r_drop      <= w_drop_d;
      r_inst      <= w_inst_d;
      r_inst_addr <= w_inst_addr_d;
    end
  end

  assign mem_req_o    = (r_state == StReq);
  assign mem_addr_o   = mem_req_o ? r_pc : '0;
  assign inst_valid_o = (r_state == StValid);
  assign inst_o       = r_inst;
  assign inst_addr_o  = r_inst_addr;
`ifdef YSYX_23060332_IFU_MISALIGN_CHK_EN
  assign misalign_o   = (r_state == StHalt);
`endif

endmodule

// File: tb/tb_ysyx_23060332_ifu.sv
// Directed table-driven bench for ysyx_23060332_ifu: each row gives the outputs expected in a
// cycle and the inputs driven during it; a short hand sequence covers the redirect alignment.
module tb_ysyx_23060332_ifu;

  logic        clk;
  logic        rst;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        jump_flag_i;
  logic [31:0] jump_addr_i;
`ifdef YSYX_23060332_IFU_MISALIGN_CHK_EN
  logic        misalign_o;
`endif

  ysyx_23060332_ifu dut (
    .clk         (clk),
    .rst         (rst),
    .mem_req_o   (mem_req_o),
    .mem_addr_o  (mem_addr_o),
    .mem_gnt_i   (mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i (mem_rdata_i),
    .inst_valid_o(inst_valid_o),
    .inst_ready_i(inst_ready_i),
    .inst_o      (inst_o),
    .inst_addr_o (inst_addr_o),
    .jump_flag_i (jump_flag_i),
`ifdef YSYX_23060332_IFU_MISALIGN_CHK_EN
    .jump_addr_i (jump_addr_i),
    .misalign_o  (misalign_o)
`else
    .jump_addr_i (jump_addr_i)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst, gnt, rv;
    logic [31:0] rdata;
    logic        rdy, jf;
    logic [31:0] ja;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_inst, e_iaddr;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_stale = 0;

  function automatic void add(input logic r, input logic g, input logic v, input logic [31:0] d,
                              input logic rd, input logic j, input logic [31:0] ja,
                              input logic eq, input logic [31:0] ea, input logic ev,
                              input logic [31:0] ei, input logic [31:0] eia);
    vec_t t;
    t.rst = r; t.gnt = g; t.rv = v; t.rdata = d; t.rdy = rd; t.jf = j; t.ja = ja;
    t.e_req = eq; t.e_addr = ea; t.e_valid = ev; t.e_inst = ei; t.e_iaddr = eia;
    vecs.push_back(t);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Stale or aborted words must never reach decode.
  always @(negedge clk) if (inst_valid_o === 1'b1 && inst_o === 32'hDEAD_BEEF) n_stale++;

  initial begin
    rst = 1'b1; mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
    inst_ready_i = 0; jump_flag_i = 0; jump_addr_i = 0;

    //   rst g v rdata         rdy j ja              req addr          vld inst          iaddr
    add(0, 0, 0, 32'h0,        0, 0, 32'h0,         0, 32'h0,         0, 32'h0,        32'h0);
    add(0, 1, 0, 32'h0,        0, 0, 32'h0,         1, 32'h80000000,  0, 32'h0,        32'h0);
    add(0, 0, 1, 32'h11111111, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,        32'h0);
    add(0, 0, 0, 32'h0,        1, 0, 32'h0,         0, 32'h0,         1, 32'h11111111, 32'h80000000);
    for (int i = 0; i < 4; i++)   // grant withheld for three cycles
      add(0, (i == 3), 0, 32'h0, 0, 0, 32'h0,       1, 32'h80000004,  0, 32'h11111111, 32'h80000000);
    add(0, 0, 0, 32'h0,        0, 0, 32'h0,         0, 32'h0,         0, 32'h11111111, 32'h80000000);
    add(0, 0, 1, 32'h22222222, 0, 0, 32'h0,         0, 32'h0,         0, 32'h11111111, 32'h80000000);
    for (int i = 0; i < 6; i++)   // five stalled cycles, then ready
      add(0, 0, 0, 32'h0, (i == 5), 0, 32'h0,       0, 32'h0,         1, 32'h22222222, 32'h80000004);
    add(0, 1, 0, 32'h0,        0, 0, 32'h0,         1, 32'h80000008,  0, 32'h22222222, 32'h80000004);
    add(0, 0, 1, 32'h33333333, 0, 0, 32'h0,         0, 32'h0,         0, 32'h22222222, 32'h80000004);
    add(0, 0, 0, 32'h0,        0, 1, 32'h80000100,  0, 32'h0,         1, 32'h33333333, 32'h80000008);
    add(0, 1, 0, 32'h0,        0, 0, 32'h0,         1, 32'h80000100,  0, 32'h33333333, 32'h80000008);
    add(0, 0, 0, 32'h0,        0, 1, 32'h80000200,  0, 32'h0,         0, 32'h33333333, 32'h80000008);
    add(0, 0, 1, 32'hDEADBEEF, 0, 0, 32'h0,         0, 32'h0,         0, 32'h33333333, 32'h80000008);
    add(0, 1, 0, 32'h0,        0, 0, 32'h0,         1, 32'h80000200,  0, 32'h33333333, 32'h80000008);
    add(0, 0, 1, 32'h44444444, 0, 0, 32'h0,         0, 32'h0,         0, 32'h33333333, 32'h80000008);
    add(0, 0, 0, 32'h0,        1, 1, 32'h80000300,  0, 32'h0,         1, 32'h44444444, 32'h80000200);
    add(0, 1, 0, 32'h0,        0, 1, 32'h80000400,  1, 32'h80000300,  0, 32'h44444444, 32'h80000200);
    add(0, 0, 1, 32'hDEADBEEF, 0, 0, 32'h0,         0, 32'h0,         0, 32'h44444444, 32'h80000200);
    add(0, 0, 0, 32'h0,        0, 1, 32'h80000500,  1, 32'h80000400,  0, 32'h44444444, 32'h80000200);
    add(0, 1, 0, 32'h0,        0, 0, 32'h0,         1, 32'h80000500,  0, 32'h44444444, 32'h80000200);
    add(1, 0, 0, 32'h0,        0, 0, 32'h0,         0, 32'h0,         0, 32'h44444444, 32'h80000200);
    add(0, 0, 1, 32'hDEADBEEF, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,        32'h0);
    add(0, 1, 0, 32'h0,        0, 0, 32'h0,         1, 32'h80000000,  0, 32'h0,        32'h0);
    add(0, 0, 1, 32'h66666666, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,        32'h0);
    add(0, 0, 0, 32'h0,        1, 0, 32'h0,         0, 32'h0,         1, 32'h66666666, 32'h80000000);
    add(0, 1, 0, 32'h0,        0, 0, 32'h0,         1, 32'h80000004,  0, 32'h66666666, 32'h80000000);
    add(0, 0, 1, 32'h77777777, 0, 0, 32'h0,         0, 32'h0,         0, 32'h66666666, 32'h80000000);
    add(0, 0, 0, 32'h0,        0, 1, 32'hFFFFFFFC,  0, 32'h0,         1, 32'h77777777, 32'h80000004);
    add(0, 1, 0, 32'h0,        0, 0, 32'h0,         1, 32'hFFFFFFFC,  0, 32'h77777777, 32'h80000004);
    add(0, 0, 1, 32'h88888888, 0, 0, 32'h0,         0, 32'h0,         0, 32'h77777777, 32'h80000004);
    add(0, 0, 0, 32'h0,        1, 0, 32'h0,         0, 32'h0,         1, 32'h88888888, 32'hFFFFFFFC);
    add(0, 0, 0, 32'h0,        0, 0, 32'h0,         1, 32'h00000000,  0, 32'h88888888, 32'hFFFFFFFC);
    add(1, 0, 0, 32'h0,        0, 0, 32'h0,         1, 32'h00000000,  0, 32'h88888888, 32'hFFFFFFFC);
    add(0, 0, 0, 32'h0,        0, 1, 32'h80000010,  0, 32'h0,         0, 32'h0,        32'h0);
    add(0, 0, 0, 32'h0,        0, 0, 32'h0,         1, 32'h80000010,  0, 32'h0,        32'h0);

    repeat (2) @(posedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      chk($sformatf("v%0d.req", i),   {31'b0, mem_req_o},    {31'b0, vecs[i].e_req});
      chk($sformatf("v%0d.addr", i),  mem_addr_o,            vecs[i].e_addr);
      chk($sformatf("v%0d.valid", i), {31'b0, inst_valid_o}, {31'b0, vecs[i].e_valid});
      chk($sformatf("v%0d.inst", i),  inst_o,                vecs[i].e_inst);
      chk($sformatf("v%0d.iaddr", i), inst_addr_o,           vecs[i].e_iaddr);
      rst          = vecs[i].rst;
      mem_gnt_i    = vecs[i].gnt;
      mem_rvalid_i = vecs[i].rv;
      mem_rdata_i  = vecs[i].rdata;
      inst_ready_i = vecs[i].rdy;
      jump_flag_i  = vecs[i].jf;
      jump_addr_i  = vecs[i].ja;
    end

    // Misaligned redirect while in REQ.
    @(negedge clk);
    jump_flag_i = 1'b1; jump_addr_i = 32'h80000102;
    @(negedge clk);
    jump_flag_i = 1'b0; jump_addr_i = 32'h0;
`ifdef YSYX_23060332_IFU_MISALIGN_CHK_EN
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("halt%0d.misalign", i), {31'b0, misalign_o},   32'd1);
      chk($sformatf("halt%0d.req", i),      {31'b0, mem_req_o},    32'd0);
      chk($sformatf("halt%0d.valid", i),    {31'b0, inst_valid_o}, 32'd0);
      mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1;
      @(negedge clk);
    end
`else
    chk("align.req",  {31'b0, mem_req_o}, 32'd1);
    chk("align.addr", mem_addr_o,         32'h80000100);
`endif
    chk("stale_never_presented", n_stale, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
